// File: rtl/ber_pkg.sv
// Shared definitions for the bit-error-rate monitor.
//   ber_state_e : alignment state (searching for delay / locked to it)
//   Def*        : default block length, lock/loss thresholds and frame length
package ber_pkg;

  typedef enum logic [0:0] {
    StSearch,
    StLocked
  } ber_state_e;

  localparam int unsigned DefWin      = 32;
  localparam int unsigned DefSyncTh   = 2;
  localparam int unsigned DefLossTh   = 8;
  localparam int unsigned DefMeasBits = 65536;

endpackage

// File: rtl/ber_delay_line.sv
// Reference history for the BER monitor: shifts the reference bit on every strobe and
// returns the reference as seen `delay` strobes earlier.
//   clk, reset : system clock, synchronous active-high reset
//   bit_en     : bit strobe; history shifts only on strobes
//   ref_bit    : current reference bit
//   delay      : tap select, 0 = current ref_bit, d = ref_bit from d strobes ago
//   tap        : selected reference bit (combinational)
module ber_delay_line #(
  parameter int unsigned DLY_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             ref_bit,
  input  logic [DLY_W-1:0] delay,
  output logic             tap
);

  localparam int unsigned Depth = 2 ** DLY_W;

  // The oldest history bit can never be selected (max delay is Depth-1), so it is not stored.
  logic [Depth-2:0] ref_sr_q;
  logic [Depth-1:0] tap_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_sr_q <= '0;
    end else if (bit_en) begin
      ref_sr_q <= {ref_sr_q[Depth-3:0], ref_bit};
    end
  end

  // Index 0 is the live input, index d is ref_sr[d-1].
  assign tap_vec = {ref_sr_q, ref_bit};
  assign tap     = tap_vec[delay];

endmodule

// File: rtl/ber_monitor.sv
// Bit-error-rate monitor. Searches for the delay between the decoded stream and the
// local reference M-sequence, locks to it, and counts bit errors over fixed frames.
//   clk, reset : system clock, synchronous active-high reset
//   bit_en     : one-cycle strobe marking a valid rx_bit/ref_bit pair
//   rx_bit     : decoded bit
//   ref_bit    : reference M-sequence bit
//   clear      : zero counters and results; lock state, delay and history kept
//   locked     : delay alignment found
//   delay      : current candidate / locked delay
//   err_pulse  : one-cycle pulse per mismatch while locked
//   meas_done  : one-cycle pulse when a frame completes
//   meas_err   : error count of the last completed frame
//   run_err    : running error count of the current frame
//   run_bits   : running bit count of the current frame
module ber_monitor
  import ber_pkg::*;
#(
  parameter int unsigned DLY_W     = 5,
  parameter int unsigned WIN       = DefWin,
  parameter int unsigned SYNC_TH   = DefSyncTh,
  parameter int unsigned LOSS_TH   = DefLossTh,
  parameter int unsigned MEAS_BITS = DefMeasBits,
  parameter int unsigned CNT_W     = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             rx_bit,
  input  logic             ref_bit,
  input  logic             clear,
  output logic             locked,
  output logic [DLY_W-1:0] delay,
  output logic             err_pulse,
  output logic             meas_done,
  output logic [CNT_W-1:0] meas_err,
  output logic [CNT_W-1:0] run_err,
  output logic [CNT_W-1:0] run_bits
);

  localparam int unsigned WinCntW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned WinErrW = $clog2(WIN + 1);

  ber_state_e       state_q, state_d;
  logic [DLY_W-1:0] delay_q, delay_d;
  logic [WinCntW-1:0] win_cnt_q, win_cnt_d;
  logic [WinErrW-1:0] win_err_q, win_err_d;
  logic [CNT_W-1:0] run_bits_q, run_bits_d;
  logic [CNT_W-1:0] run_err_q, run_err_d;
  logic [CNT_W-1:0] meas_err_q, meas_err_d;
  logic             meas_done_q, meas_done_d;
  logic             err_pulse_q, err_pulse_d;

  logic               tap;
  logic               mismatch;
  logic               win_last;
  logic [WinErrW-1:0] win_total;
  logic [CNT_W-1:0]   bits_inc;
  logic [CNT_W-1:0]   err_inc;

  ber_delay_line #(
    .DLY_W (DLY_W)
  ) u_delay_line (
    .clk     (clk),
    .reset   (reset),
    .bit_en  (bit_en),
    .ref_bit (ref_bit),
    .delay   (delay_q),
    .tap     (tap)
  );

  assign mismatch  = rx_bit ^ tap;
  assign win_last  = (win_cnt_q == WinCntW'(WIN - 1));
  // Block total including the current bit; win_err never exceeds WIN-1 before this add.
  assign win_total = win_err_q + WinErrW'(mismatch);
  assign bits_inc  = run_bits_q + CNT_W'(1);
  assign err_inc   = run_err_q + CNT_W'(mismatch);

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    run_bits_d  = run_bits_q;
    run_err_d   = run_err_q;
    meas_err_d  = meas_err_q;
    meas_done_d = 1'b0;
    err_pulse_d = 1'b0;

    if (clear) begin
      // Clear beats a coincident strobe: the bit is dropped, only the history shifts.
      win_cnt_d  = '0;
      win_err_d  = '0;
      run_bits_d = '0;
      run_err_d  = '0;
      meas_err_d = '0;
    end else if (bit_en) begin
      if (win_last) begin
        win_cnt_d = '0;
        win_err_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        win_err_d = win_total;
      end

      unique case (state_q)
        StSearch: begin
          if (win_last) begin
            if (win_total <= WinErrW'(SYNC_TH)) begin
              state_d    = StLocked;
              run_bits_d = '0;
              run_err_d  = '0;
            end else begin
              delay_d = delay_q + 1'b1;
            end
          end
        end
        StLocked: begin
          err_pulse_d = mismatch;
          run_bits_d  = bits_inc;
          run_err_d   = err_inc;
          if (bits_inc == CNT_W'(MEAS_BITS)) begin
            meas_err_d  = err_inc;
            meas_done_d = 1'b1;
            run_bits_d  = '0;
            run_err_d   = '0;
          end
          // Loss is evaluated after frame completion so a coincident frame still reports.
          if (win_last && (win_total > WinErrW'(LOSS_TH))) begin
            state_d    = StSearch;
            run_bits_d = '0;
            run_err_d  = '0;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StSearch;
      delay_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      run_bits_q  <= '0;
      run_err_q   <= '0;
      meas_err_q  <= '0;
      meas_done_q <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      run_bits_q  <= run_bits_d;
      run_err_q   <= run_err_d;
      meas_err_q  <= meas_err_d;
      meas_done_q <= meas_done_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign delay     = delay_q;
  assign err_pulse = err_pulse_q;
  assign meas_done = meas_done_q;
  assign meas_err  = meas_err_q;
  assign run_err   = run_err_q;
  assign run_bits  = run_bits_q;

endmodule

// File: tb/tb_ber_monitor.sv
// Directed testbench for ber_monitor: lock, frame counting, loss/relock, clear,
// mid-frame reset and delay wrap. PN7 reference, rx is the reference delayed 5 strobes.
module tb_ber_monitor;

  localparam int unsigned DlyW  = 5;
  localparam int unsigned CntW  = 24;
  localparam int unsigned Frame = 4096;

  logic            clk = 1'b0;
  logic            reset;
  logic            bit_en;
  logic            rx_bit;
  logic            ref_bit;
  logic            clear;
  logic            locked;
  logic [DlyW-1:0] delay;
  logic            err_pulse;
  logic            meas_done;
  logic [CntW-1:0] meas_err;
  logic [CntW-1:0] run_err;
  logic [CntW-1:0] run_bits;

  int n_chk  = 0;
  int n_fail = 0;
  int ep_cnt = 0;
  int md_cnt = 0;

  logic [6:0]  lfsr    = 7'h7f;
  logic [31:0] hist    = '0;  // hist[k] = reference bit from k+1 strobes ago
  logic        rx_zero = 1'b0;

  always #5 clk = ~clk;

  ber_monitor #(
    .DLY_W     (DlyW),
    .MEAS_BITS (Frame),
    .CNT_W     (CntW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_en    (bit_en),
    .rx_bit    (rx_bit),
    .ref_bit   (ref_bit),
    .clear     (clear),
    .locked    (locked),
    .delay     (delay),
    .err_pulse (err_pulse),
    .meas_done (meas_done),
    .meas_err  (meas_err),
    .run_err   (run_err),
    .run_bits  (run_bits)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One bit strobe; flip inverts rx relative to the aligned stream.
  task automatic strobe(input logic flip, input logic clr);
    logic r;
    r       = lfsr[6];
    ref_bit = r;
    rx_bit  = (rx_zero ? 1'b0 : hist[4]) ^ flip;
    bit_en  = 1'b1;
    clear   = clr;
    @(posedge clk);
    #1;
    hist   = {hist[30:0], r};
    lfsr   = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    bit_en = 1'b0;
    clear  = 1'b0;
    if (err_pulse) ep_cnt++;
    if (meas_done) md_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rx_bit  = ~hist[4];
      ref_bit = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_delay"}, 32'(delay), 0);
    chk({tag, "_err_pulse"}, 32'(err_pulse), 0);
    chk({tag, "_meas_done"}, 32'(meas_done), 0);
    chk({tag, "_meas_err"}, 32'(meas_err), 0);
    chk({tag, "_run_err"}, 32'(run_err), 0);
    chk({tag, "_run_bits"}, 32'(run_bits), 0);
  endtask

  initial begin
    reset   = 1'b1;
    bit_en  = 1'b0;
    rx_bit  = 1'b0;
    ref_bit = 1'b0;
    clear   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // Lock: delay steps 0..5, one 32-bit window each, locks after strobe 192.
    for (int i = 1; i <= 192; i++) begin
      strobe(1'b0, 1'b0);
      if (i == 32)  chk("lock_delay_after_w1", 32'(delay), 1);
      if (i == 160) chk("lock_delay_after_w5", 32'(delay), 5);
      if (i == 191) chk("lock_not_yet", 32'(locked), 0);
    end
    chk("lock_locked", 32'(locked), 1);
    chk("lock_delay", 32'(delay), 5);
    chk("lock_run_bits", 32'(run_bits), 0);
    chk("lock_no_pulses", 32'(ep_cnt), 0);

    // Frame: 40 flips at offsets 7,107,...,3907.
    ep_cnt = 0;
    md_cnt = 0;
    for (int i = 0; i < int'(Frame); i++) begin
      strobe(((i % 100) == 7) && (i < 4000), 1'b0);
      if (i == 1999) begin
        chk("frame_mid_run_bits", 32'(run_bits), 2000);
        chk("frame_mid_run_err", 32'(run_err), 20);
      end
      if (i == int'(Frame) - 2) chk("frame_no_early_done", 32'(md_cnt), 0);
    end
    chk("frame_meas_done", 32'(meas_done), 1);
    chk("frame_done_count", 32'(md_cnt), 1);
    chk("frame_meas_err", 32'(meas_err), 40);
    chk("frame_err_pulses", 32'(ep_cnt), 40);
    chk("frame_run_err", 32'(run_err), 0);
    chk("frame_run_bits", 32'(run_bits), 0);

    // Loss: 9 flips inside one aligned block.
    for (int i = 0; i < 32; i++) begin
      strobe((i >= 10) && (i <= 18), 1'b0);
      if (i == 0) chk("loss_done_is_pulse", 32'(meas_done), 0);
      if (i == 30) chk("loss_still_locked", 32'(locked), 1);
    end
    chk("loss_locked", 32'(locked), 0);
    chk("loss_delay", 32'(delay), 5);
    chk("loss_run_bits", 32'(run_bits), 0);
    chk("loss_meas_err_kept", 32'(meas_err), 40);

    // Relock on clean data at the kept delay.
    for (int i = 0; i < 32; i++) begin
      strobe(1'b0, 1'b0);
      if (i == 30) chk("relock_not_yet", 32'(locked), 0);
    end
    chk("relock_locked", 32'(locked), 1);
    chk("relock_delay", 32'(delay), 5);

    // Clear coinciding with a mismatching strobe.
    for (int i = 0; i < 10; i++) strobe(1'b0, 1'b0);
    chk("pre_clear_run_bits", 32'(run_bits), 10);
    strobe(1'b1, 1'b1);
    chk("clear_run_err", 32'(run_err), 0);
    chk("clear_run_bits", 32'(run_bits), 0);
    chk("clear_err_pulse", 32'(err_pulse), 0);
    chk("clear_locked", 32'(locked), 1);
    chk("clear_meas_err", 32'(meas_err), 0);
    chk("clear_delay", 32'(delay), 5);
    strobe(1'b0, 1'b0);
    chk("post_clear_err_pulse", 32'(err_pulse), 0);
    chk("post_clear_run_bits", 32'(run_bits), 1);
    idle(3);
    chk("idle_run_bits", 32'(run_bits), 1);
    chk("idle_run_err", 32'(run_err), 0);

    // Reset mid-frame.
    for (int i = 0; i < 999; i++) strobe(1'b0, 1'b0);
    chk("pre_reset_run_bits", 32'(run_bits), 1000);
    reset  = 1'b1;
    bit_en = 1'b1;
    clear  = 1'b1;
    rx_bit = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    bit_en = 1'b0;
    clear  = 1'b0;
    hist   = '0;
    chk_all_zero("midreset");

    // Wrap: rx stuck at 0 never locks; delay walks 0..31 and wraps.
    rx_zero = 1'b1;
    for (int i = 1; i <= 1024; i++) begin
      strobe(1'b0, 1'b0);
      if (i == 992) begin
        chk("wrap_delay_31", 32'(delay), 31);
        chk("wrap_unlocked_31", 32'(locked), 0);
      end
    end
    chk("wrap_delay_0", 32'(delay), 0);
    chk("wrap_unlocked", 32'(locked), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ber_monitor.md
Name: ber_monitor

Overview:
- Bit-error-rate monitor at the receive end of the link. Compares the Viterbi decoder output bit stream against the local reference M-sequence (m_out2).
- Searches for the bit delay between the two streams, locks to it, then counts bit errors over fixed-length measurement frames.
- Results go to the display/LED logic and the test bench.
- Purely downstream of the decoder. It never back-pressures the chain.

Parameters:
- DLY_W, 5: width of the delay search index. Maximum delay is 2^DLY_W-1 = 31 bit periods.
- WIN, 32: bits per search/loss-check block.
- SYNC_TH, 2: maximum mismatches in one block that still allow lock.
- LOSS_TH, 8: more mismatches than this in one locked block declares loss of lock.
- MEAS_BITS, 65536: bits per measurement frame. Must be <= 2^CNT_W-1.
- CNT_W, 24: width of the bit and error counters.

Ports:
- clk, in, 1: single system clock. Everything is on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- bit_en, in, 1: one-cycle strobe. One new bit pair is valid on this cycle (decoder bit-rate tick).
- rx_bit, in, 1: decoded bit (decoder_out).
- ref_bit, in, 1: reference M-sequence bit (m_out2).
- clear, in, 1: synchronous clear of counters and results. Lock state is kept.
- locked, out, 1: delay alignment found.
- delay, out, DLY_W: current candidate/locked delay.
- err_pulse, out, 1: one-cycle pulse on each locked-state mismatch (LED drive).
- meas_done, out, 1: one-cycle pulse when a frame completes.
- meas_err, out, CNT_W: error count of the last completed frame. Held until the next frame completes.
- run_err, out, CNT_W: running error count of the current frame.
- run_bits, out, CNT_W: running bit count of the current frame.

Behaviour:
- Reset: state SEARCH, delay=0, every counter 0, every output 0, reference shift register 0.
- All work happens only on cycles with bit_en=1. Between strobes all state holds.
- Reference history:
  - ref_sr is 2^DLY_W bits. On each strobe, ref_bit shifts into ref_sr[0].
  - tap(d) is ref_bit as seen d strobes earlier: tap(0) is the current ref_bit input, tap(d) is ref_sr[d-1].
  - mismatch = rx_bit XOR tap(delay).
- SEARCH state:
  - win_cnt runs 0..WIN-1 and win_err accumulates mismatches.
  - On the strobe with win_cnt=WIN-1, compute total = win_err + mismatch.
  - If total <= SYNC_TH: go to LOCKED. locked=1 from the next cycle. Clear the frame counters.
  - Otherwise: delay <= delay+1, wrapping from 2^DLY_W-1 to 0. Restart the window. ref_sr is not flushed.
- LOCKED state:
  - Each strobe: run_bits+1, run_err+mismatch, err_pulse=mismatch on the next cycle.
  - The block checker uses the same win_cnt/win_err. At block end, if total > LOSS_TH: go to SEARCH, locked=0 on the next cycle, delay unchanged.
  - On loss of lock the frame counters clear and meas_err is kept.
- Frame end:
  - On the strobe that makes run_bits reach MEAS_BITS, latch meas_err = run_err + mismatch and pulse meas_done on the next cycle.
  - run_bits and run_err restart at 0.
  - If frame end and loss of lock fall on the same strobe, the frame is completed first (meas_done fires), then the state goes to SEARCH.
- Counters never exceed MEAS_BITS, so no saturation logic is needed.
- clear=1:
  - Zeroes run_bits, run_err, meas_err and the window counters. State, delay and ref_sr are kept.
  - If it coincides with bit_en, clear wins and the bit is not counted. ref_sr still shifts.
- reset mid-operation: returns to the reset state on the next edge, regardless of bit_en or clear.
- Latency: all outputs are registered, one clk after the qualifying strobe.

Decomposition:
- Shared package (ber_pkg) holds:
  - the state enum {SEARCH, LOCKED};
  - default constants for WIN, SYNC_TH, LOSS_TH and MEAS_BITS.
- One sub-module, ber_delay_line: the ref_sr shift register plus the tap mux. Inputs are clk, reset, bit_en, ref_bit and delay; output is the tap bit.
- The FSM and counters stay in ber_monitor.

Test Plan:
- Lock: PN7 reference, rx = ref delayed 5 strobes, no errors -> delay steps 0..5. locked=1 one cycle after strobe 192 (6 windows). delay=5.
- Frame count: MEAS_BITS=4096, locked, flip rx on 40 chosen bits -> meas_done pulses once after strobe 4096 of the frame. meas_err=40. 40 err_pulses are seen. run_err resets to 0.
- Loss: locked, then 9 consecutive flips inside one block -> locked=0 one cycle after that block's last strobe. delay stays 5. Clean data relocks after 32 strobes.
- Wrap: rx tied to 0 -> never locks. delay goes 31 -> 0 after 32 windows (1024 strobes).
- Clear/simultaneity: clear with bit_en while rx mismatches -> run_err unchanged (0), no err_pulse, locked unchanged.
- Reset mid-frame at run_bits=1000 -> the next cycle shows all outputs 0, delay=0, locked=0.
